// File: rtl/mod_counter_pkg.sv
// Shared clock-datapath constants: unit bounds, repeat timing defaults and
// repeat FSM state encodings used by mod_counter and its step repeater.
package mod_counter_pkg;

  localparam int SEC_MAX   = 59;
  localparam int MIN_MAX   = 59;
  localparam int HOUR_MAX  = 23;
  localparam int DAY_MIN   = 1;
  localparam int MONTH_MIN = 1;
  localparam int MONTH_MAX = 12;

  localparam int REPEAT_DELAY_DEF  = 50000000;
  localparam int REPEAT_PERIOD_DEF = 10000000;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

endpackage

// File: rtl/mod_counter_step_repeater.sv
// Turns held inc/dec button levels into single-cycle up/down steps:
// immediate step on press, then auto-repeat after a hold delay.
module mod_counter_step_repeater
  import mod_counter_pkg::*;
#(
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic inc,
  input  logic dec,
  output logic up_step,
  output logic down_step
);

  localparam int MAX_CNT = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  logic             inc_q, dec_q;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held, rise, step;

  assign held = enable & (inc | dec);
  assign rise = (inc & ~inc_q) | (dec & ~dec_q);

  // The entry cycle counts as the first held cycle, so the counter starts at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable && rise) begin
          step    = 1'b1;
          state_d = ST_HOLD;
          cnt_d   = ONE_C;
        end
      end
      ST_HOLD: begin
        if (!held) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= DELAY_C) begin
          step    = 1'b1;
          state_d = ST_REPEAT;
          cnt_d   = ONE_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      ST_REPEAT: begin
        if (!held) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= PERIOD_C) begin
          step  = 1'b1;
          cnt_d = ONE_C;
        end else begin
          cnt_d = cnt_q + ONE_C;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      inc_q   <= inc;
      dec_q   <= dec;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign up_step   = step & inc;
  assign down_step = step & dec & ~inc;

endmodule

// File: rtl/mod_counter.sv
// Modulo counter with run-time upper bound, cascade tick, set-mode inc/dec,
// load, freeze and registered carry. Define AUTOREPEAT_EN for held-button auto-repeat.
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int WIDTH         = 6,
  parameter int MIN_VAL       = 0,
  parameter int RST_VAL       = 0,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             ctrl_set,
  input  logic             inc,
  input  logic             dec,
  input  logic             freeze,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] RST_V = WIDTH'(RST_VAL);

  if (RST_VAL < MIN_VAL || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("mod_counter: invalid parameter combination");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] eff;
  logic [WIDTH:0]   eff_up, eff_dn;
  logic             up_step, down_step;

`ifdef AUTOREPEAT_EN
  mod_counter_step_repeater #(
    .REPEAT_DELAY  (REPEAT_DELAY),
    .REPEAT_PERIOD (REPEAT_PERIOD)
  ) u_step_repeater (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (ctrl_set & ~freeze),
    .inc       (inc),
    .dec       (dec),
    .up_step   (up_step),
    .down_step (down_step)
  );
`else
  assign up_step   = inc;
  assign down_step = dec & ~inc;
`endif

  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v,
                                                  input logic [WIDTH-1:0] hi);
    if (v > hi)          return hi;
    else if (v <= MIN_V) return MIN_V;
    else                 return v;
  endfunction

  assign eff    = (count_q > max_val) ? max_val : count_q;
  assign eff_up = {1'b0, eff} + {{WIDTH{1'b0}}, 1'b1};
  assign eff_dn = {1'b0, eff} - {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    count_d = count_q;
    carry_d = 1'b0;
    if (freeze) begin
      count_d = count_q;
    end else if (load) begin
      count_d = clamp_load(load_val, max_val);
    end else if (ctrl_set && up_step) begin
      count_d = (eff == max_val) ? MIN_V : eff_up[WIDTH-1:0];
    end else if (ctrl_set && down_step) begin
      count_d = (eff == MIN_V) ? max_val : eff_dn[WIDTH-1:0];
    end else if (!ctrl_set && tick) begin
      if (eff == max_val) begin
        count_d = MIN_V;
        carry_d = 1'b1;
      end else begin
        count_d = eff_up[WIDTH-1:0];
      end
    end else if (count_q > max_val) begin
      // Bound shrank under us (e.g. 31st into a 30-day month): pull back in range.
      count_d = max_val;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= RST_V;
      carry_q <= 1'b0;
    end else begin
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  assign count     = count_q;
  assign carry_out = carry_q;
  assign at_max    = (count_q >= max_val);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: a 0-based seconds-style instance and a
// 1-based day-style instance sharing clock, reset and control inputs.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick, tick1, ctrl_set, inc, dec, freeze, load;
  logic [5:0] load_val, max_val, max1;
  logic [5:0] count, count1;
  logic       carry_out, carry1, at_max, at_max1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_counter #(
    .WIDTH(6), .MIN_VAL(0), .RST_VAL(0), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .ctrl_set(ctrl_set), .inc(inc),
    .dec(dec), .freeze(freeze), .load(load), .load_val(load_val),
    .max_val(max_val), .count(count), .carry_out(carry_out), .at_max(at_max)
  );

  mod_counter #(
    .WIDTH(6), .MIN_VAL(1), .RST_VAL(1), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .tick(tick1), .ctrl_set(1'b0), .inc(inc),
    .dec(dec), .freeze(freeze), .load(load), .load_val(load_val),
    .max_val(max1), .count(count1), .carry_out(carry1), .at_max(at_max1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 0; tick1 = 0; ctrl_set = 0; inc = 0; dec = 0;
    freeze = 0; load = 0; load_val = 0; max_val = 6'd59; max1 = 6'd31;
    #12;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry got=%b want=0", carry_out); end
    checks++; if (count1 !== 6'd1) begin errors++; $display("FAIL reset_count1 got=%0d want=1", count1); end
    checks++; if (at_max !== 1'b0) begin errors++; $display("FAIL reset_at_max got=%b want=0", at_max); end
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_tick_wrap();
    load_val = 6'd58; load = 1; step(); load = 0;
    checks++; if (count !== 6'd58) begin errors++; $display("FAIL wrap_load got=%0d want=58", count); end
    tick = 1; step();
    checks++; if (count !== 6'd59) begin errors++; $display("FAIL wrap_59 got=%0d want=59", count); end
    checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL wrap_at_max got=%b want=1", at_max); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL wrap_nocarry got=%b want=0", carry_out); end
    step(); tick = 0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL wrap_0 got=%0d want=0", count); end
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL wrap_carry got=%b want=1", carry_out); end
    step();
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL wrap_carry_end got=%b want=0", carry_out); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL wrap_hold got=%0d want=0", count); end
  endtask

  task automatic test_day_shrink();
    max1 = 6'd31; load_val = 6'd31; load = 1; step(); load = 0;
    checks++; if (count1 !== 6'd31) begin errors++; $display("FAIL day_load got=%0d want=31", count1); end
    max1 = 6'd30; step();
    checks++; if (count1 !== 6'd30) begin errors++; $display("FAIL day_clamp got=%0d want=30", count1); end
    tick1 = 1; step(); tick1 = 0;
    checks++; if (count1 !== 6'd1) begin errors++; $display("FAIL day_wrap got=%0d want=1", count1); end
    checks++; if (carry1 !== 1'b1) begin errors++; $display("FAIL day_carry got=%b want=1", carry1); end
    step();
    checks++; if (carry1 !== 1'b0) begin errors++; $display("FAIL day_carry_end got=%b want=0", carry1); end
  endtask

  task automatic test_set_mode();
    load_val = 6'd0; load = 1; step(); load = 0;
    ctrl_set = 1; tick = 1;
    dec = 1; step(); dec = 0;
    checks++; if (count !== 6'd59) begin errors++; $display("FAIL set_dec_wrap got=%0d want=59", count); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL set_dec_carry got=%b want=0", carry_out); end
    step();
    checks++; if (count !== 6'd59) begin errors++; $display("FAIL set_tick_ignored got=%0d want=59", count); end
    inc = 1; step(); inc = 0;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL set_inc_wrap got=%0d want=0", count); end
    step();
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL set_inc_carry got=%b want=0", carry_out); end
    inc = 1; dec = 1; step(); inc = 0; dec = 0;
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL set_inc_priority got=%0d want=1", count); end
    step();
    ctrl_set = 0; tick = 0;
  endtask

  task automatic test_freeze();
    freeze = 1; tick = 1; inc = 1; load = 1; load_val = 6'd30;
    step();
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL freeze_hold got=%0d want=1", count); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL freeze_carry got=%b want=0", carry_out); end
    step();
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL freeze_hold2 got=%0d want=1", count); end
    freeze = 0; load = 0; inc = 0; tick = 0; step();
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL freeze_release got=%0d want=1", count); end
    tick = 1; step(); tick = 0;
    checks++; if (count !== 6'd2) begin errors++; $display("FAIL freeze_resume got=%0d want=2", count); end
  endtask

  task automatic test_load();
    max_val = 6'd23; load_val = 6'd45; load = 1; step();
    checks++; if (count !== 6'd23) begin errors++; $display("FAIL load_above got=%0d want=23", count); end
    checks++; if (at_max !== 1'b1) begin errors++; $display("FAIL load_at_max got=%b want=1", at_max); end
    checks++; if (count1 !== 6'd30) begin errors++; $display("FAIL load_above1 got=%0d want=30", count1); end
    load_val = 6'd10; tick = 1; step(); load = 0; tick = 0;
    checks++; if (count !== 6'd10) begin errors++; $display("FAIL load_vs_tick got=%0d want=10", count); end
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL load_carry got=%b want=0", carry_out); end
    load_val = 6'd0; load = 1; step(); load = 0;
    checks++; if (count1 !== 6'd1) begin errors++; $display("FAIL load_below_min got=%0d want=1", count1); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL load_zero got=%0d want=0", count); end
    max_val = 6'd59;
  endtask

  task automatic test_back_to_back_and_async_reset();
    max_val = 6'd0; tick = 1; load_val = 6'd20; load = 1; step(); load = 0;
    checks++; if (count1 !== 6'd20) begin errors++; $display("FAIL b2b_load1 got=%0d want=20", count1); end
    step();
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL b2b_carry1 got=%b want=1", carry_out); end
    step();
    checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL b2b_carry2 got=%b want=1", carry_out); end
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL b2b_count got=%0d want=0", count); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL areset_carry got=%b want=0", carry_out); end
    checks++; if (count1 !== 6'd1) begin errors++; $display("FAIL areset_count1 got=%0d want=1", count1); end
    tick = 0; max_val = 6'd59;
    @(negedge clk); rst_n = 1'b1;
    step();
  endtask

`ifdef AUTOREPEAT_EN
  task automatic test_autorepeat();
    ctrl_set = 1; inc = 1;
    repeat (5) step();
    checks++; if (count !== 6'd2) begin errors++; $display("FAIL ar_after5 got=%0d want=2", count); end
    repeat (5) step();
    checks++; if (count !== 6'd4) begin errors++; $display("FAIL ar_after10 got=%0d want=4", count); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (count !== 6'd0) begin errors++; $display("FAIL ar_reset got=%0d want=0", count); end
    @(negedge clk); rst_n = 1'b1;
    step();
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL ar_restart got=%0d want=1", count); end
    repeat (3) step();
    checks++; if (count !== 6'd1) begin errors++; $display("FAIL ar_idle_restart got=%0d want=1", count); end
    inc = 0; ctrl_set = 0;
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_tick_wrap();
    test_day_shrink();
    test_set_mode();
    test_freeze();
    test_load();
    test_back_to_back_and_async_reset();
`ifdef AUTOREPEAT_EN
    test_autorepeat();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mod_counter.md
# mod_counter

Parametrised modulo counter for the clock datapath that generalises the fixed 0-59 seconds counter to any time unit (seconds, minutes, hours, day-of-month, month, year digits). It supports a run-time upper bound, a cascade tick input, set-mode inc/dec with wrap, synchronous load, freeze and a registered carry pulse for chaining. Instances are chained carry_out to tick to build the full calendar chain.

## Interface
- WIDTH, 6: counter width in bits
- MIN_VAL, 0: lowest count value (1 for day/month units)
- RST_VAL, 0: count value after reset; must lie in [MIN_VAL, 2^WIDTH-1]
- REPEAT_DELAY, 50000000: clk cycles a button is held before auto-repeat starts (AUTOREPEAT_EN only)
- REPEAT_PERIOD, 10000000: clk cycles between auto-repeat steps (AUTOREPEAT_EN only)

- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  normal-mode advance strobe, one step per asserted cycle (1 Hz enable or lower-unit carry_out)
- ctrl_set  in  1  set mode: tick ignored, inc/dec active
- inc  in  1  step up (set mode)
- dec  in  1  step down (set mode)
- freeze  in  1  hold all state
- load  in  1  synchronous load of load_val
- load_val  in  WIDTH  value for load
- max_val  in  WIDTH  run-time top value, inclusive; must be >= MIN_VAL
- count  out  WIDTH  current value
- carry_out  out  1  registered one-cycle pulse, cycle after a tick-driven wrap
- at_max  out  1  combinational, count >= max_val

## Operation
- Reset: count = RST_VAL, carry_out = 0, repeat FSM = IDLE, edge registers = 0.
- Effective value eff = min(count, max_val); all arithmetic uses eff.
- Per-cycle priority: freeze > load > ctrl_set > tick > clamp.
- freeze: count and carry_out hold (carry_out forced 0); repeat FSM forced to IDLE, edge registers still sample inc/dec.
- load: count <= load_val if in [MIN_VAL, max_val], else max_val if above, MIN_VAL if below. No carry.
- ctrl_set: up-step: eff==max_val -> MIN_VAL, else eff+1. Down-step: eff==MIN_VAL -> max_val, else eff-1. inc has priority over dec. Never generates carry. tick ignored.
- tick (ctrl_set=0): eff==max_val -> count <= MIN_VAL and carry_out pulses next cycle; else count <= eff+1.
- clamp: no action and count > max_val -> count <= max_val (handles max_val shrinking, e.g. day 31 -> 30-day month).
- Arithmetic done in WIDTH+1 bits; no overflow possible when max_val <= 2^WIDTH-1.

## Timing
- count updates on the clk edge where the action is sampled; visible same cycle as registered output, zero extra latency.
- carry_out asserted exactly one cycle, the cycle after count wraps; tick on consecutive cycles with max_val==MIN_VAL gives carry every cycle.
- Reset asserted mid-operation clears immediately (async), including a pending carry_out.

## Configuration
- AUTOREPEAT_EN defined: inc/dec are held button levels. Rising edge steps once immediately; FSM IDLE -> HOLD. HOLD counts REPEAT_DELAY cycles while held, then step and -> REPEAT. REPEAT steps every REPEAT_PERIOD cycles while held. Release, ctrl_set=0 or freeze -> IDLE. Both inc and dec held: inc wins.
- Not defined: inc/dec are single-cycle strobes; every asserted cycle steps once; no FSM or delay counters synthesised.

## Structure
- Shared clock package: unit constants (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23, DAY_MIN=1, MONTH_MIN=1, MONTH_MAX=12), repeat timing defaults, repeat FSM state enum (IDLE, HOLD, REPEAT).
- One sub-module: step_repeater (edge detect + repeat FSM + delay counter, outputs up_step/down_step), instantiated under AUTOREPEAT_EN; bypass wiring otherwise.

## Test plan
- WIDTH=6, MIN_VAL=0, max_val=59, count=58, two ticks -> count 59 then 0; carry_out=1 only the cycle after reaching 0.
- MIN_VAL=1, max_val=31, count=31, max_val -> 30 with no tick -> count 30 next cycle; tick -> 1 plus carry.
- ctrl_set=1, count=0, dec strobe -> 59, inc strobe -> 0, tick pulses ignored, carry_out stays 0.
- freeze=1 with tick, inc and load asserted -> count unchanged; release -> resumes on next tick.
- load_val=45 with max_val=23 -> count 23; load_val=10 same cycle as tick -> count 10.
- AUTOREPEAT_EN, REPEAT_DELAY=4, REPEAT_PERIOD=2, inc held 10 cycles from count 0 -> steps at cycles 0, 4, 6, 8 -> count 4; rst_n low mid-hold -> count RST_VAL, FSM IDLE.
